// File: rtl/combo_lock_n_if.sv
// rtl/combo_lock_n_if.sv - button, code and status bundle of the combination lock
interface combo_lock_n_if #(
   parameter int DIGITS    = 4,
   parameter int DIGIT_W   = 4,
   parameter int MAX_TRIES = 3
);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FAIL_W = $clog2(MAX_TRIES + 1);

   logic                      next_btn;
   logic                      enter_btn;
   logic [DIGITS*DIGIT_W-1:0] code;
   logic [DIGIT_W-1:0]        digit;
   logic [IDX_W-1:0]          digit_idx;
   logic                      unlocked;
   logic                      locked_out;
   logic [FAIL_W-1:0]         fail_cnt;
   logic [1:0]                state;

   // board side: drives raw buttons and the secret code, watches status
   modport master (
      output next_btn, enter_btn, code,
      input  digit, digit_idx, unlocked, locked_out, fail_cnt, state
   );

   // lock side
   modport slave (
      input  next_btn, enter_btn, code,
      output digit, digit_idx, unlocked, locked_out, fail_cnt, state
   );
endinterface

// File: rtl/combo_lock_n.sv
// rtl/combo_lock_n.sv - two-button combination lock with lockout; optional COMBO_LOCK_AUTO_RELOCK_EN
module combo_lock_n #(
   parameter int DIGITS         = 4,
   parameter int DIGIT_W        = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int RELOCK_CYCLES  = 5000
) (
   input  logic          clk,
   input  logic          rst_n,
   combo_lock_n_if.slave bus
);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FAIL_W = $clog2(MAX_TRIES + 1);
   localparam int LCNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [LCNT_W-1:0] LCNT_END = LCNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

   typedef enum logic [1:0] {
      ST_ENTRY    = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_LOCKOUT  = 2'd2,
      ST_BAD      = 2'd3
   } state_t;

   state_t             r_state;
   logic [2:0]         r_next_sync;
   logic [2:0]         r_enter_sync;
   logic [DIGIT_W-1:0] r_digit;
   logic [IDX_W-1:0]   r_idx;
   logic [FAIL_W-1:0]  r_fail_cnt;
   logic               r_mismatch;
   logic [LCNT_W-1:0]  r_lock_cnt;

   logic               w_next_pulse;
   logic               w_enter_pulse;
   logic [DIGIT_W-1:0] w_code_digit;
   logic               w_neq;
   logic               w_fail;

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
   localparam int RCNT_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
   localparam logic [RCNT_W-1:0] RCNT_END = RCNT_W'(RELOCK_CYCLES - 1);
   logic [RCNT_W-1:0] r_relock_cnt;
`endif

   // bit 0/1 synchronise the raw level, bit 2 is the previous synchronised value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_next_sync  <= '0;
         r_enter_sync <= '0;
      end else begin
         r_next_sync  <= {r_next_sync[1:0], bus.next_btn};
         r_enter_sync <= {r_enter_sync[1:0], bus.enter_btn};
      end
   end

   assign w_next_pulse  = r_next_sync[1] & ~r_next_sync[2];
   assign w_enter_pulse = r_enter_sync[1] & ~r_enter_sync[2];

   assign w_code_digit = bus.code[int'(r_idx)*DIGIT_W +: DIGIT_W];
   assign w_neq        = (w_code_digit != r_digit);
   // verdict of the whole attempt once the last digit is committed
   assign w_fail       = r_mismatch | w_neq;

   // lock FSM: digit entry, verdict, lockout timer and (optionally) relock timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ENTRY;
         r_digit    <= '0;
         r_idx      <= '0;
         r_fail_cnt <= '0;
         r_mismatch <= 1'b0;
         r_lock_cnt <= '0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
         r_relock_cnt <= '0;
`endif
      end else begin
         case (r_state)
            ST_ENTRY: begin
               // enter has priority; a coincident next is dropped
               if (w_enter_pulse) begin
                  r_digit <= '0;
                  if (r_idx < IDX_LAST) begin
                     r_idx      <= r_idx + 1'b1;
                     r_mismatch <= w_fail;
                  end else begin
                     r_idx      <= '0;
                     r_mismatch <= 1'b0;
                     if (!w_fail) begin
                        r_state    <= ST_UNLOCKED;
                        r_fail_cnt <= '0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
                        r_relock_cnt <= '0;
`endif
                     end else if ((int'(r_fail_cnt) + 1) < MAX_TRIES) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                     end else begin
                        r_fail_cnt <= FAIL_MAX;
                        r_state    <= ST_LOCKOUT;
                        r_lock_cnt <= '0;
                     end
                  end
               end else if (w_next_pulse) begin
                  r_digit <= r_digit + 1'b1;
               end
            end
            ST_UNLOCKED: begin
               if (w_enter_pulse) begin
                  r_state <= ST_ENTRY;
                  r_digit <= '0;
                  r_idx   <= '0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
                  r_relock_cnt <= '0;
               end else if (r_relock_cnt == RCNT_END) begin
                  r_state      <= ST_ENTRY;
                  r_digit      <= '0;
                  r_idx        <= '0;
                  r_relock_cnt <= '0;
               end else begin
                  r_relock_cnt <= r_relock_cnt + 1'b1;
`endif
               end
            end
            ST_LOCKOUT: begin
               // buttons are ignored here; pulses are simply lost
               if (r_lock_cnt == LCNT_END) begin
                  r_state    <= ST_ENTRY;
                  r_fail_cnt <= '0;
                  r_lock_cnt <= '0;
               end else begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_ENTRY;
               r_digit <= '0;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign bus.digit      = r_digit;
   assign bus.digit_idx  = r_idx;
   assign bus.fail_cnt   = r_fail_cnt;
   assign bus.state      = r_state;
   assign bus.unlocked   = (r_state == ST_UNLOCKED);
   assign bus.locked_out = (r_state == ST_LOCKOUT);
endmodule

// File: tb/tb_combo_lock_n.sv
// tb/tb_combo_lock_n.sv - randomized self-checking bench for combo_lock_n
module tb_combo_lock_n;
   localparam int DIGITS    = 4;
   localparam int DIGIT_W   = 4;
   localparam int MAX_TRIES = 3;
   localparam int LOCK_CYC  = 60;
   localparam int RELOCK    = 20;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   combo_lock_n_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

   combo_lock_n #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
      .LOCKOUT_CYCLES(LOCK_CYC), .RELOCK_CYCLES(RELOCK)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // reference model: digits entered so far, verdict at the last one, deadlines for timed states
   int m_state, m_digit, m_idx, m_fail, m_deadline, m_unlock_t;
   int m_ent[DIGITS];
   int m_cd[DIGITS];

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_state = 0; m_digit = 0; m_idx = 0; m_fail = 0;
   endtask

   // settle timed transitions that happened at or before edge c
   task automatic m_advance(input int c);
      if (m_state == 2 && c >= m_deadline) begin
         m_state = 0; m_fail = 0;
      end
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
      if (m_state == 1 && c >= m_deadline) begin
         m_state = 0; m_digit = 0; m_idx = 0;
      end
`endif
   endtask

   // button pulse(s) taking effect at edge t
   task automatic m_event(input bit nx, input bit en, input int t);
      bit ok;
      m_advance(t - 1);
      if (m_state == 0) begin
         if (en) begin
            m_ent[m_idx] = m_digit;
            m_cd[m_idx]  = int'((bus.code >> (DIGIT_W * m_idx)) & ((1 << DIGIT_W) - 1));
            m_digit = 0;
            if (m_idx < DIGITS - 1) m_idx++;
            else begin
               ok = 1'b1;
               for (int i = 0; i < DIGITS; i++) if (m_ent[i] != m_cd[i]) ok = 1'b0;
               m_idx = 0;
               if (ok) begin
                  m_state = 1; m_fail = 0; m_deadline = t + RELOCK; m_unlock_t = t;
               end else if (m_fail + 1 < MAX_TRIES) begin
                  m_fail++;
               end else begin
                  m_fail = MAX_TRIES; m_state = 2; m_deadline = t + LOCK_CYC;
               end
            end
         end else if (nx) begin
            m_digit = (m_digit + 1) % (1 << DIGIT_W);
         end
      end else if (m_state == 1) begin
         if (en) begin
            m_state = 0; m_digit = 0; m_idx = 0;
         end
      end
      m_advance(t);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // raise buttons at a negedge; the pulse acts three edges later
   task automatic press(input bit nx, input bit en, input int hold, input int gap, output int t);
      bus.next_btn  = nx;
      bus.enter_btn = en;
      t = cyc + 3;
      m_event(nx, en, t);
      repeat (hold) @(negedge clk);
      bus.next_btn  = 1'b0;
      bus.enter_btn = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic rpress(input bit nx, input bit en);
      int t;
      press(nx, en, $urandom_range(1, 3), $urandom_range(1, 3), t);
   endtask

   task automatic enter_digit(input int v);
      for (int i = 0; i < v; i++) rpress(1'b1, 1'b0);
      rpress(1'b0, 1'b1);
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      m_advance(cyc);
      chk({tag, ".state"},      int'(bus.state),      m_state);
      chk({tag, ".digit"},      int'(bus.digit),      m_digit);
      chk({tag, ".digit_idx"},  int'(bus.digit_idx),  m_idx);
      chk({tag, ".fail_cnt"},   int'(bus.fail_cnt),   m_fail);
      chk({tag, ".unlocked"},   int'(bus.unlocked),   (m_state == 1) ? 1 : 0);
      chk({tag, ".locked_out"}, int'(bus.locked_out), (m_state == 2) ? 1 : 0);
   endtask

   task automatic attempt(input string tag, input int a, input int b, input int c, input int d);
      enter_digit(a); enter_digit(b); enter_digit(c); enter_digit(d);
      settle();
      check_all(tag);
   endtask

   task automatic relock(input string tag);
      rpress(1'b0, 1'b1);
      settle();
      check_all(tag);
   endtask

   // reset lands between clock edges; outputs must clear without a clock
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, ".state"},      int'(bus.state),      0);
      chk({tag, ".digit"},      int'(bus.digit),      0);
      chk({tag, ".digit_idx"},  int'(bus.digit_idx),  0);
      chk({tag, ".fail_cnt"},   int'(bus.fail_cnt),   0);
      chk({tag, ".unlocked"},   int'(bus.unlocked),   0);
      chk({tag, ".locked_out"}, int'(bus.locked_out), 0);
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      settle();
      check_all({tag, ".after"});
   endtask

   initial begin
      int t, dl;
      int d[DIGITS];
      bus.next_btn  = 1'b0;
      bus.enter_btn = 1'b0;
      bus.code      = 16'h3A51;
      rst_n         = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("reset");

      // correct code, with the unlock latency measured on the last enter
      enter_digit(1); enter_digit(5); enter_digit(10);
      for (int i = 0; i < 3; i++) rpress(1'b1, 1'b0);
      press(1'b0, 1'b1, 1, 0, t);
      wait_cyc(t - 1);
      chk("unlock_lat.early", int'(bus.unlocked), 0);
      wait_cyc(t);
      chk("unlock_lat.edge", int'(bus.unlocked), 1);
      settle();
      check_all("good_code");
      rpress(1'b1, 1'b0);
      settle();
      check_all("unlocked_next_ignored");
      relock("relock1");

      // one wrong attempt then the right one
      attempt("wrong1", 1, 5, 10, 4);
      chk("wrong1.fail_const", int'(bus.fail_cnt), 1);
      attempt("good_after_wrong", 1, 5, 10, 3);
      relock("relock2");

      // lockout after MAX_TRIES failures, presses ignored, exact duration
      attempt("lk_try1", 0, 0, 0, 0);
      attempt("lk_try2", 2, 5, 10, 3);
      attempt("lk_try3", 1, 5, 10, 2);
      chk("lockout.const", int'(bus.locked_out), 1);
      dl = m_deadline;
      rpress(1'b1, 1'b0);
      rpress(1'b0, 1'b1);
      rpress(1'b1, 1'b1);
      settle();
      check_all("lockout_presses");
      wait_cyc(dl - 1);
      chk("lockout.last_cycle", int'(bus.state), 2);
      wait_cyc(dl);
      chk("lockout.exit_state", int'(bus.state), 0);
      chk("lockout.exit_fail", int'(bus.fail_cnt), 0);
      check_all("lockout_exit");

      // wrap after 17 presses, then simultaneous next+enter commits 1
      for (int i = 0; i < 17; i++) rpress(1'b1, 1'b0);
      settle();
      check_all("wrap17");
      chk("wrap17.const", int'(bus.digit), 1);
      rpress(1'b1, 1'b1);
      settle();
      check_all("simul");
      enter_digit(5); enter_digit(10); enter_digit(3);
      settle();
      check_all("simul_unlock");
      relock("relock3");

      // held button yields a single increment
      press(1'b1, 1'b0, 100, 2, t);
      settle();
      check_all("held100");
      chk("held100.const", int'(bus.digit), 1);

      // async reset mid-entry and mid-lockout
      enter_digit(2); enter_digit(3);
      settle();
      check_all("mid_entry");
      async_reset("rst_entry");
      attempt("rl_try1", 0, 1, 0, 0);
      attempt("rl_try2", 0, 2, 0, 0);
      attempt("rl_try3", 0, 3, 0, 0);
      async_reset("rst_lock");

      // random attempts with random codes
      for (int it = 0; it < 14; it++) begin
         if ($urandom_range(0, 2) == 0) bus.code = 16'($urandom);
         for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 1) == 0) d[i] = int'((bus.code >> (DIGIT_W * i)) & 16'hF);
            else d[i] = $urandom_range(0, 15);
         end
         attempt("rand", d[0], d[1], d[2], d[3]);
         if (m_state == 1) relock("rand_relock");
         else if (m_state == 2) begin
            wait_cyc(m_deadline + 1);
            check_all("rand_lock_exit");
         end
      end

      // timed relock behaviour
      attempt("relock_unlock", int'(bus.code[3:0]), int'(bus.code[7:4]),
              int'(bus.code[11:8]), int'(bus.code[15:12]));
      chk("relock_unlock.const", int'(bus.unlocked), 1);
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
      wait_cyc(m_unlock_t + RELOCK - 1);
      chk("auto_relock.before", int'(bus.state), 1);
      wait_cyc(m_unlock_t + RELOCK);
      chk("auto_relock.after", int'(bus.state), 0);
      check_all("auto_relock");
`else
      wait_cyc(m_unlock_t + 1000);
      chk("no_auto_relock", int'(bus.state), 1);
      check_all("no_auto_relock");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
